// File: rtl/sd_fifo_head_mc.sv
// Multi-channel FIFO write-side head: per-channel ring pointers, full tracking,
// optional write/commit/abort, and a round-robin arbiter onto one RAM write port.
module sd_fifo_head_mc #(
  parameter int unsigned channels = 4,
  parameter int unsigned depth    = 64,
  parameter bit          commit   = 1'b0,
  parameter int unsigned asz      = $clog2(depth),
  parameter int unsigned csz      = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [channels-1:0]     c_srdy,
  output logic [channels-1:0]     c_drdy,
  input  logic [channels-1:0]     c_commit,
  input  logic [channels-1:0]     c_abort,
  input  logic [channels*asz-1:0] bound_low,
  input  logic [channels*asz-1:0] bound_high,
  input  logic [channels*asz-1:0] rdptr,
  output logic [channels*asz-1:0] cur_wrptr,
  output logic [channels*asz-1:0] com_wrptr,
  output logic [channels-1:0]     ch_full,
  output logic                    mem_we,
  output logic [asz-1:0]          mem_addr,
  output logic [csz-1:0]          mem_sel
);

  logic [channels-1:0] w_elig;
  logic [csz-1:0]      r_rr_ptr;
  logic [csz-1:0]      w_gidx;
  logic                w_gvld;
  logic [csz:0]        w_cand;

  // Round-robin search starting at r_rr_ptr; first eligible channel wins this cycle.
  always_comb begin
    w_gvld = 1'b0;
    w_gidx = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < channels; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (csz+1)'(k);
      if (w_cand >= (csz+1)'(channels)) w_cand = w_cand - (csz+1)'(channels);
      if (!w_gvld && w_elig[w_cand[csz-1:0]]) begin
        w_gvld = 1'b1;
        w_gidx = w_cand[csz-1:0];
      end
    end
  end

  always_comb begin
    c_drdy = '0;
    if (w_gvld) c_drdy[w_gidx] = 1'b1;
  end

  assign mem_we   = w_gvld;
  assign mem_addr = w_gvld ? cur_wrptr[w_gidx*asz +: asz] : '0;
  assign mem_sel  = w_gvld ? w_gidx : '0;

  always_ff @(posedge clk) begin
    if (!reset_n)    r_rr_ptr <= '0;
    else if (w_gvld) r_rr_ptr <= (w_gidx == csz'(channels-1)) ? '0 : w_gidx + csz'(1);
  end

  for (genvar i = 0; i < channels; i++) begin : g_ch
    logic [asz-1:0] w_lo, w_hi, w_rd, w_p1, w_com;
    logic [asz-1:0] r_cur;
    logic           r_full;
    logic           w_abort, w_gnt;

    assign w_lo      = bound_low[i*asz +: asz];
    assign w_hi      = bound_high[i*asz +: asz];
    assign w_rd      = rdptr[i*asz +: asz];
    assign w_abort   = commit & c_abort[i];
    assign w_gnt     = w_gvld & (w_gidx == csz'(i));
    assign w_elig[i] = reset_n & enable & c_srdy[i] & ~r_full & ~w_abort;
    assign w_p1      = (r_cur == w_hi) ? w_lo : r_cur + asz'(1);

    // After rollback the channel stays full only if nothing was uncommitted and it was full.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_cur  <= w_lo;
        r_full <= 1'b0;
      end else if (w_abort) begin
        r_cur  <= w_com;
        r_full <= r_full & (r_cur == w_com) & (w_com == w_rd);
      end else if (w_gnt) begin
        r_cur  <= w_p1;
        r_full <= (w_p1 == w_rd);
      end else begin
        r_full <= r_full & (r_cur == w_rd);
      end
    end

    if (commit) begin : g_com
      logic [asz-1:0] r_com;
      always_ff @(posedge clk) begin
        if (!reset_n)                r_com <= w_lo;
        else if (w_gnt & c_commit[i]) r_com <= w_p1;
      end
      assign w_com = r_com;
    end else begin : g_nocom
      assign w_com = r_cur;
    end

    assign cur_wrptr[i*asz +: asz] = r_cur;
    assign com_wrptr[i*asz +: asz] = w_com;
    assign ch_full[i]              = r_full;
  end

  if (!commit) begin : g_nocommit_tie
    logic w_unused_commit;
    assign w_unused_commit = ^c_commit;
  end

endmodule
